// File: rtl/spi_proto_pkg.sv
// Shared definitions for the image-transfer SPI protocol: opcodes, channel codes,
// job encoding, sequencer states and the command-byte builder.
package spi_proto_pkg;

  localparam logic [3:0] OP_UPLOAD   = 4'b0001;
  localparam logic [3:0] OP_DOWNLOAD = 4'b0010;
  localparam logic [3:0] OP_RUN      = 4'b0011;
  localparam logic [3:0] OP_RES_BASE = 4'b0100;

  localparam logic [1:0] CH_R = 2'b01;
  localparam logic [1:0] CH_G = 2'b10;
  localparam logic [1:0] CH_B = 2'b11;

  localparam logic [7:0] PDI_BUSY_BYTE = 8'h40;
  localparam int unsigned IMG_PIXELS_DEFAULT = 76800;

  typedef enum logic [1:0] {
    JOB_UPLOAD   = 2'd0,
    JOB_DOWNLOAD = 2'd1,
    JOB_RUN      = 2'd2,
    JOB_RESULT   = 2'd3
  } job_op_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_HDR, ST_PIX_RD, ST_PIX_TX,
    ST_DL, ST_PDI_WAIT, ST_RES, ST_DONE
  } state_t;

  // Result reads fold the selector into the opcode and send channel bits 00.
  function automatic logic [7:0] cmd_byte(input job_op_t op, input logic [1:0] ch);
    logic [7:0] b;
    b = 8'h00;
    unique case (op)
      JOB_UPLOAD:   b = {2'b00, OP_UPLOAD, ch};
      JOB_DOWNLOAD: b = {2'b00, OP_DOWNLOAD, ch};
      JOB_RUN:      b = {2'b00, OP_RUN, ch};
      default:      b = {2'b00, OP_RES_BASE + {2'b00, ch}, 2'b00};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_issuer.sv
// Byte-level handshake to the SPI master: launches one transfer at a time and
// keeps a countdown of the transfers remaining in the current phase.
module spi_byte_issuer
  import spi_proto_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [7:0]  issue_byte,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        spi_done,
  output logic        spi_start,
  output logic [7:0]  spi_tx_byte,
  output logic        busy,
  output logic [31:0] count
);

  logic        spi_start_reg;
  logic [7:0]  tx_byte_reg;
  logic        busy_reg;
  logic [31:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      spi_start_reg <= 1'b0;
      tx_byte_reg   <= 8'h00;
      busy_reg      <= 1'b0;
      count_reg     <= 32'd0;
    end else begin
      spi_start_reg <= 1'b0;
      // A new strobe is only honoured once the previous transfer has completed.
      if (issue && !busy_reg) begin
        spi_start_reg <= 1'b1;
        tx_byte_reg   <= issue_byte;
        busy_reg      <= 1'b1;
      end else if (spi_done) begin
        busy_reg <= 1'b0;
      end
      if (load)
        count_reg <= load_val;
      else if (spi_done && count_reg != 32'd0)
        count_reg <= count_reg - 32'd1;
    end
  end

  assign spi_start   = spi_start_reg;
  assign spi_tx_byte = tx_byte_reg;
  assign busy        = busy_reg;
  assign count       = count_reg;

endmodule

// File: rtl/spi_host_sequencer.sv
// Host-side command sequencer for the image-transfer SPI protocol.
// Define SPI_HOST_TIMEOUT_EN to abandon run jobs after PDI_TIMEOUT wait cycles.
module spi_host_sequencer
  import spi_proto_pkg::*;
#(
  parameter int unsigned DL_BYTES    = IMG_PIXELS_DEFAULT,
  parameter int unsigned DL_SKIP     = 1,
  parameter int unsigned RES_XFERS   = 5,
  parameter int unsigned PDI_TIMEOUT = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [1:0]  job_op,
  input  logic [1:0]  job_channel,
  input  logic [15:0] job_height,
  input  logic [15:0] job_width,
  output logic        job_done,
  output logic        job_timeout,
  output logic [31:0] result_data,
  output logic        spi_start,
  output logic [7:0]  spi_tx_byte,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx_byte,
  output logic [16:0] src_addr,
  input  logic [7:0]  src_data,
  output logic [16:0] snk_addr,
  output logic        snk_we,
  output logic [7:0]  snk_data,
  input  logic        pdi_done_in
);

  state_t      state_reg;
  job_op_t     op_reg;
  logic [1:0]  ch_reg;
  logic [15:0] height_reg, width_reg;
  logic [31:0] pix_count_reg, pix_idx_reg;
  logic        sent_reg, issue_reg, load_reg;
  logic [7:0]  issue_byte_reg;
  logic [31:0] load_val_reg;
  logic        job_ready_reg, job_done_reg;
  logic [31:0] result_data_reg, res_shift_reg;
  logic [16:0] src_addr_reg, snk_ptr_reg;

  logic        busy;
  logic [31:0] count;
  logic        xfer_done, can_issue, keep_byte;
  logic [31:0] dl_idx, res_idx, pix_next, res_next;
  logic [7:0]  hdr_byte;

  spi_byte_issuer u_issuer (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue_reg),
    .issue_byte (issue_byte_reg),
    .load       (load_reg),
    .load_val   (load_val_reg),
    .spi_done   (spi_done),
    .spi_start  (spi_start),
    .spi_tx_byte(spi_tx_byte),
    .busy       (busy),
    .count      (count)
  );

  assign xfer_done = sent_reg && spi_done;
  // Hold off while a countdown load is in flight so byte selection sees the new count.
  assign can_issue = !sent_reg && !busy && !load_reg;
  assign dl_idx    = 32'(DL_BYTES) - count;
  assign res_idx   = 32'(RES_XFERS) - count;
  assign pix_next  = pix_idx_reg + 32'd1;
  assign res_next  = {res_shift_reg[23:0], spi_rx_byte};
  assign keep_byte = (state_reg == ST_DL) && xfer_done && (dl_idx >= 32'(DL_SKIP));

  always_comb begin
    hdr_byte = width_reg[7:0];
    unique case (count[2:0])
      3'd4:    hdr_byte = height_reg[15:8];
      3'd3:    hdr_byte = height_reg[7:0];
      3'd2:    hdr_byte = width_reg[15:8];
      default: hdr_byte = width_reg[7:0];
    endcase
  end

`ifdef SPI_HOST_TIMEOUT_EN
  logic [31:0] wait_cnt_reg;
  logic        job_timeout_reg;
  assign job_timeout = job_timeout_reg;
`else
  assign job_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      op_reg          <= JOB_UPLOAD;
      ch_reg          <= 2'b00;
      height_reg      <= 16'd0;
      width_reg       <= 16'd0;
      pix_count_reg   <= 32'd0;
      pix_idx_reg     <= 32'd0;
      sent_reg        <= 1'b0;
      issue_reg       <= 1'b0;
      issue_byte_reg  <= 8'h00;
      load_reg        <= 1'b0;
      load_val_reg    <= 32'd0;
      job_ready_reg   <= 1'b1;
      job_done_reg    <= 1'b0;
      result_data_reg <= 32'd0;
      res_shift_reg   <= 32'd0;
      src_addr_reg    <= 17'd0;
      snk_ptr_reg     <= 17'd0;
`ifdef SPI_HOST_TIMEOUT_EN
      wait_cnt_reg    <= 32'd0;
      job_timeout_reg <= 1'b0;
`endif
    end else begin
      issue_reg    <= 1'b0;
      load_reg     <= 1'b0;
      job_done_reg <= 1'b0;
`ifdef SPI_HOST_TIMEOUT_EN
      job_timeout_reg <= 1'b0;
`endif
      if (xfer_done) sent_reg <= 1'b0;
      if (keep_byte) snk_ptr_reg <= snk_ptr_reg + 17'd1;

      unique case (state_reg)
        ST_IDLE: if (job_valid) begin
          op_reg        <= job_op_t'(job_op);
          ch_reg        <= job_channel;
          height_reg    <= job_height;
          width_reg     <= job_width;
          pix_count_reg <= {16'd0, job_height} * {16'd0, job_width};
          snk_ptr_reg   <= 17'd0;
          job_ready_reg <= 1'b0;
          state_reg     <= ST_CMD;
        end
        ST_CMD: begin
          if (can_issue) begin
            issue_reg <= 1'b1; issue_byte_reg <= cmd_byte(op_reg, ch_reg); sent_reg <= 1'b1;
          end else if (xfer_done) begin
            unique case (op_reg)
              JOB_UPLOAD: begin
                load_reg <= 1'b1; load_val_reg <= 32'd4; state_reg <= ST_HDR;
              end
              JOB_DOWNLOAD: begin
                load_reg <= 1'b1; load_val_reg <= 32'(DL_BYTES);
                if (DL_BYTES == 0) begin job_done_reg <= 1'b1; state_reg <= ST_DONE; end
                else state_reg <= ST_DL;
              end
              JOB_RUN: begin
`ifdef SPI_HOST_TIMEOUT_EN
                wait_cnt_reg <= 32'd0;
`endif
                state_reg <= ST_PDI_WAIT;
              end
              default: begin
                load_reg <= 1'b1; load_val_reg <= 32'(RES_XFERS);
                if (RES_XFERS == 0) begin job_done_reg <= 1'b1; state_reg <= ST_DONE; end
                else state_reg <= ST_RES;
              end
            endcase
          end
        end
        ST_HDR: begin
          if (can_issue) begin
            issue_reg <= 1'b1; issue_byte_reg <= hdr_byte; sent_reg <= 1'b1;
          end else if (xfer_done && count == 32'd1) begin
            if (pix_count_reg == 32'd0) begin
              job_done_reg <= 1'b1; state_reg <= ST_DONE;
            end else begin
              pix_idx_reg <= 32'd0; src_addr_reg <= 17'd0; state_reg <= ST_PIX_RD;
            end
          end
        end
        // src_addr is already valid here; RAM data appears in PIX_TX.
        ST_PIX_RD: state_reg <= ST_PIX_TX;
        ST_PIX_TX: begin
          if (can_issue) begin
            issue_reg <= 1'b1; issue_byte_reg <= src_data; sent_reg <= 1'b1;
          end else if (xfer_done) begin
            if (pix_next == pix_count_reg) begin
              job_done_reg <= 1'b1; state_reg <= ST_DONE;
            end else begin
              pix_idx_reg <= pix_next; src_addr_reg <= pix_next[16:0]; state_reg <= ST_PIX_RD;
            end
          end
        end
        ST_DL: begin
          if (can_issue) begin
            issue_reg <= 1'b1; issue_byte_reg <= 8'h00; sent_reg <= 1'b1;
          end else if (xfer_done && count == 32'd1) begin
            job_done_reg <= 1'b1; state_reg <= ST_DONE;
          end
        end
        ST_PDI_WAIT: begin
          if (pdi_done_in) begin
            job_done_reg <= 1'b1; state_reg <= ST_DONE;
          end
`ifdef SPI_HOST_TIMEOUT_EN
          else if (wait_cnt_reg == 32'(PDI_TIMEOUT) - 32'd1) begin
            job_timeout_reg <= 1'b1; job_ready_reg <= 1'b1; state_reg <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
`endif
        end
        ST_RES: begin
          if (can_issue) begin
            issue_reg <= 1'b1; issue_byte_reg <= 8'h00; sent_reg <= 1'b1;
          end else if (xfer_done) begin
            // The first received byte is the responder's status and is discarded.
            if (res_idx >= 32'd1) res_shift_reg <= res_next;
            if (count == 32'd1) begin
              result_data_reg <= (res_idx >= 32'd1) ? res_next : res_shift_reg;
              job_done_reg <= 1'b1; state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          job_ready_reg <= 1'b1; state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign job_ready   = job_ready_reg;
  assign job_done    = job_done_reg;
  assign result_data = result_data_reg;
  assign src_addr    = src_addr_reg;
  assign snk_addr    = snk_ptr_reg;
  assign snk_we      = keep_byte;
  assign snk_data    = keep_byte ? spi_rx_byte : 8'h00;

endmodule

// File: tb/tb_spi_host_sequencer.sv
// Directed bench for spi_host_sequencer with an SPI responder and source/sink RAM models.
module tb_spi_host_sequencer;

  localparam int DLB = 4;
  localparam int TMO = 20;
`ifdef SPI_HOST_TIMEOUT_EN
  localparam int PDI_DELAY = 10;
`else
  localparam int PDI_DELAY = 100;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [1:0]  job_op = 2'd0;
  logic [1:0]  job_channel = 2'd0;
  logic [15:0] job_height = 16'd0;
  logic [15:0] job_width = 16'd0;
  logic        job_done, job_timeout;
  logic [31:0] result_data;
  logic        spi_start;
  logic [7:0]  spi_tx_byte;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx_byte = 8'h00;
  logic [16:0] src_addr;
  logic [7:0]  src_data = 8'h00;
  logic [16:0] snk_addr;
  logic        snk_we;
  logic [7:0]  snk_data;
  logic        pdi_done_in = 1'b0;

  always #5 clk = ~clk;

  spi_host_sequencer #(
    .DL_BYTES(DLB), .DL_SKIP(1), .RES_XFERS(5), .PDI_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op),
    .job_channel(job_channel), .job_height(job_height), .job_width(job_width),
    .job_done(job_done), .job_timeout(job_timeout), .result_data(result_data),
    .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_done(spi_done),
    .spi_rx_byte(spi_rx_byte), .src_addr(src_addr), .src_data(src_data),
    .snk_addr(snk_addr), .snk_we(snk_we), .snk_data(snk_data),
    .pdi_done_in(pdi_done_in)
  );

  // SPI responder: fixed 3-cycle transfer, rx bytes from rx_mem relative to rx_base.
  logic [7:0] rx_mem [0:15];
  logic [7:0] tx_log [0:255];
  int rx_base = 0;
  int xfer_cnt = 0;
  int done_seen = 0;
  int pend = 0;

  always @(posedge clk) begin
    spi_done <= 1'b0;
    if (!rst) begin
      pend <= 0;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end else if (pend == 1) begin
      pend <= 0;
      spi_done <= 1'b1;
      spi_rx_byte <= rx_mem[4'(xfer_cnt - 1 - rx_base)];
    end else if (spi_start) begin
      tx_log[8'(xfer_cnt)] <= spi_tx_byte;
      xfer_cnt <= xfer_cnt + 1;
      pend <= 3;
    end
  end

  always @(posedge clk) if (spi_done) done_seen <= done_seen + 1;

  logic [7:0] src_mem [0:15];
  always @(posedge clk) src_data <= src_mem[src_addr[3:0]];

  logic [16:0] snk_addr_log [0:15];
  logic [7:0]  snk_data_log [0:15];
  int snk_n = 0;
  always @(posedge clk) if (snk_we) begin
    snk_addr_log[4'(snk_n)] <= snk_addr;
    snk_data_log[4'(snk_n)] <= snk_data;
    snk_n <= snk_n + 1;
  end

  int done_cnt = 0;
  int tmo_cnt = 0;
  always @(posedge clk) begin
    if (job_done) done_cnt <= done_cnt + 1;
    if (job_timeout) tmo_cnt <= tmo_cnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] op, input logic [1:0] ch,
                           input logic [15:0] h, input logic [15:0] w);
    int guard;
    guard = 0;
    while (!job_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_job", {31'd0, job_ready}, 32'd1);
    rx_base = xfer_cnt;
    job_op = op; job_channel = ch; job_height = h; job_width = w;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    $display("job op=%0d ch=%0d h=%0d w=%0d issued", op, ch, h, w);
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (!job_done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_done_seen"}, {31'd0, job_done}, 32'd1);
    check({tag, "_ready_low_at_done"}, {31'd0, job_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_after_done"}, {31'd0, job_ready}, 32'd1);
  endtask

  task automatic wait_first_xfer(input int base);
    int guard;
    guard = 0;
    while (done_seen <= base && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_xfer_completed", {31'd0, done_seen > base}, 32'd1);
  endtask

  logic [7:0] up_exp [0:10];
  logic [7:0] rd_exp [0:5];

  initial begin
    int base, dbase, sbase, guard, n;
    for (int i = 0; i < 16; i++) begin
      src_mem[i] = 8'(8'h10 + i);
      rx_mem[i] = 8'hEE;
    end
    up_exp[0] = 8'h05; up_exp[1] = 8'h00; up_exp[2] = 8'h02;
    up_exp[3] = 8'h00; up_exp[4] = 8'h03;
    for (int i = 0; i < 6; i++) up_exp[5 + i] = 8'(8'h10 + i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_job_ready", {31'd0, job_ready}, 32'd1);
    check("rst_spi_start", {31'd0, spi_start}, 32'd0);
    check("rst_job_done", {31'd0, job_done}, 32'd0);
    check("rst_job_timeout", {31'd0, job_timeout}, 32'd0);
    check("rst_result", result_data, 32'd0);
    check("rst_src_addr", {15'd0, src_addr}, 32'd0);
    check("rst_snk_we", {31'd0, snk_we}, 32'd0);
    check("rst_tx_byte", {24'd0, spi_tx_byte}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Upload channel R, 2x3
    dbase = done_cnt;
    start_job(2'd0, 2'b01, 16'd2, 16'd3);
    base = rx_base;
    wait_done("upload");
    check("up_xfers", 32'(xfer_cnt - base), 32'd11);
    for (int i = 0; i < 11; i++)
      check($sformatf("up_tx%0d", i), {24'd0, tx_log[8'(base + i)]}, {24'd0, up_exp[i]});
    check("up_last_src_addr", {15'd0, src_addr}, 32'd5);
    check("up_done_count", 32'(done_cnt - dbase), 32'd1);

    // Download channel B, 4 dummies, first rx discarded
    rx_mem[1] = 8'hAA; rx_mem[2] = 8'h01; rx_mem[3] = 8'h02; rx_mem[4] = 8'h03;
    sbase = snk_n;
    start_job(2'd1, 2'b11, 16'd0, 16'd0);
    base = rx_base;
    wait_done("download");
    check("dl_xfers", 32'(xfer_cnt - base), 32'd5);
    check("dl_tx_cmd", {24'd0, tx_log[8'(base)]}, 32'h0B);
    for (int i = 1; i < 5; i++)
      check($sformatf("dl_tx%0d", i), {24'd0, tx_log[8'(base + i)]}, 32'h00);
    check("dl_snk_writes", 32'(snk_n - sbase), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dl_snk_addr%0d", i), {15'd0, snk_addr_log[4'(sbase + i)]}, 32'(i));
      check($sformatf("dl_snk_data%0d", i), {24'd0, snk_data_log[4'(sbase + i)]}, 32'(i + 1));
    end

    // pdi_done_in while idle is ignored
    dbase = done_cnt;
    pdi_done_in = 1'b1;
    @(negedge clk);
    pdi_done_in = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_pdi_ready", {31'd0, job_ready}, 32'd1);
    check("idle_pdi_no_done", 32'(done_cnt - dbase), 32'd0);

    // Run PDI
    base = xfer_cnt;
    n = done_seen;
    start_job(2'd2, 2'b00, 16'd0, 16'd0);
    wait_first_xfer(n);
    repeat (PDI_DELAY) @(negedge clk);
    check("run_wait_no_done", {31'd0, job_done}, 32'd0);
    check("run_wait_busy", {31'd0, job_ready}, 32'd0);
    pdi_done_in = 1'b1;
    @(negedge clk);
    pdi_done_in = 1'b0;
    check("run_done_next_cycle", {31'd0, job_done}, 32'd1);
    check("run_tx_cmd", {24'd0, tx_log[8'(base)]}, 32'h0C);
    check("run_xfers", 32'(xfer_cnt - base), 32'd1);
    @(negedge clk);
    check("run_ready_after", {31'd0, job_ready}, 32'd1);
    check("run_no_timeout", 32'(tmo_cnt), 32'd0);

    // Read result: peaks
    rx_mem[1] = 8'h40; rx_mem[2] = 8'h00; rx_mem[3] = 8'h00; rx_mem[4] = 8'h01; rx_mem[5] = 8'h2C;
    rd_exp[0] = 8'h18;
    for (int i = 1; i < 6; i++) rd_exp[i] = 8'h00;
    start_job(2'd3, 2'd2, 16'd0, 16'd0);
    base = rx_base;
    wait_done("result");
    check("res_xfers", 32'(xfer_cnt - base), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("res_tx%0d", i), {24'd0, tx_log[8'(base + i)]}, {24'd0, rd_exp[i]});
    check("res_data", result_data, 32'h0000012C);

`ifdef SPI_HOST_TIMEOUT_EN
    // Run with no pdi_done_in: abandoned after the timeout
    dbase = done_cnt;
    n = done_seen;
    start_job(2'd2, 2'b00, 16'd0, 16'd0);
    wait_first_xfer(n);
    n = 0;
    while (!job_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_pulse_window", {31'd0, (n >= 19 && n <= 21)}, 32'd1);
    check("tmo_ready", {31'd0, job_ready}, 32'd1);
    check("tmo_no_done", 32'(done_cnt - dbase), 32'd0);
    $display("timeout job: job_timeout after %0d wait cycles", n);
`endif

    // Reset in the middle of an upload
    dbase = done_cnt;
    start_job(2'd0, 2'b01, 16'd2, 16'd3);
    base = rx_base;
    guard = 0;
    while ((xfer_cnt - base) < 9 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reached_pixel3", {31'd0, (xfer_cnt - base) >= 9}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_spi_start", {31'd0, spi_start}, 32'd0);
    check("mid_rst_ready", {31'd0, job_ready}, 32'd1);
    check("mid_rst_done", {31'd0, job_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n = xfer_cnt;
    repeat (30) @(negedge clk);
    check("mid_no_strobes", 32'(xfer_cnt - n), 32'd0);
    check("mid_no_done", 32'(done_cnt - dbase), 32'd0);

    // A fresh job after the abort
    rx_mem[1] = 8'h40; rx_mem[2] = 8'hDE; rx_mem[3] = 8'hAD; rx_mem[4] = 8'hBE; rx_mem[5] = 8'hEF;
    start_job(2'd3, 2'd3, 16'd0, 16'd0);
    base = rx_base;
    wait_done("post_rst");
    check("post_rst_tx_cmd", {24'd0, tx_log[8'(base)]}, 32'h1C);
    check("post_rst_result", result_data, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
